// File: rtl/keypad_pkg.sv
// Keypad receive path shared types: event kinds, key codes, event word.
// Imported by the event receiver and its FIFO.
package keypad_pkg;

  localparam logic [1:0] EV_PRESS   = 2'b01;
  localparam logic [1:0] EV_RELEASE = 2'b10;
  localparam logic [1:0] EV_REPEAT  = 2'b11;

  localparam logic [3:0] KEY_0    = 4'd0;
  localparam logic [3:0] KEY_1    = 4'd1;
  localparam logic [3:0] KEY_2    = 4'd2;
  localparam logic [3:0] KEY_3    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_7    = 4'd7;
  localparam logic [3:0] KEY_8    = 4'd8;
  localparam logic [3:0] KEY_9    = 4'd9;
  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  typedef struct packed {
    logic [1:0] ev_type;
    logic [3:0] code;
  } key_event_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_SWITCH
  } rx_state_t;

  function automatic key_event_t mk_event(
    input logic [1:0] t,
    input logic [3:0] c
  );
    key_event_t e;
    e.ev_type = t;
    e.code    = c;
    return e;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO with extra-MSB pointers; reports whether a push landed.
// Ports: clk, rst_n, push/wdata/accepted, pop/rdata/empty.
module event_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             accepted,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign empty    = (wp == rp);
  assign full     = (wp[AW] != rp[AW]) &&
                    (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop   = pop && !empty;
  // Full but popping frees the slot this push writes.
  assign do_push  = push && (!full || do_pop);
  assign accepted = do_push;
  assign rdata    = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wp[AW-1:0]] <= wdata;
        wp <= wp + 1'b1;
      end
      if (do_pop) begin
        rp <= rp + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_event_rx.sv
// Debounces scanner keycodes into PRESS/RELEASE/REPEAT events, queued.
// Ports: keycode in; ev_valid/ev_ready/ev_code/ev_type, held, overflow.
module keypad_event_rx
  import keypad_pkg::*;
#(
  parameter int STABLE_CYCLES = 1024,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_RATE   = 4096,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] keycode,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [3:0] ev_code,
  output logic [1:0] ev_type,
  output logic       held,
  output logic [3:0] held_code,
  output logic       overflow,
  input  logic       clr_ovf
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(STABLE_CYCLES - 1);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] DLY_LAST =
    RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] RATE_LAST =
    RW'(REPEAT_RATE - 1);
  localparam logic [RW-1:0] REP_SAT = '1;
  localparam bit REP_EN = (REPEAT_DELAY != 0);

  logic [4:0]    samp;
  logic [4:0]    cand;
  logic [4:0]    stable;
  logic [CW-1:0] cnt;

  rx_state_t     state;
  logic [RW-1:0] rep_cnt;
  logic          rep_on;

  logic          key_up;
  logic          key_new;
  logic          key_same;
  logic          rep_fire;
  logic          push;
  key_event_t    push_ev;
  logic          push_ok;
  key_event_t    head;
  logic          fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp   <= '0;
      cand   <= '0;
      stable <= '0;
      cnt    <= '0;
    end else begin
      samp <= keycode;
      if (samp != cand) begin
        cand <= samp;
        cnt  <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= cand;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Mutually exclusive so the HELD decoders stay one-hot.
  assign key_up   = !stable[0];
  assign key_new  = stable[0] && (stable[4:1] != held_code);
  assign key_same = stable[0] && (stable[4:1] == held_code);
  // rep_on: first REPEAT already sent, now pacing at REPEAT_RATE.
  assign rep_fire = REP_EN && key_same &&
                    (rep_on ? (rep_cnt == RATE_LAST)
                            : (rep_cnt == DLY_LAST));

  always_comb begin
    push    = 1'b0;
    push_ev = '0;
    unique case (state)
      ST_IDLE: begin
        push    = stable[0];
        push_ev = mk_event(EV_PRESS, stable[4:1]);
      end
      ST_SWITCH: begin
        push    = 1'b1;
        push_ev = mk_event(EV_PRESS, stable[4:1]);
      end
      ST_HELD: begin
        push    = key_up || key_new || rep_fire;
        push_ev = mk_event(rep_fire ? EV_REPEAT : EV_RELEASE,
                           held_code);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      held      <= 1'b0;
      held_code <= '0;
      rep_cnt   <= '0;
      rep_on    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (stable[0]) begin
            state     <= ST_HELD;
            held      <= 1'b1;
            held_code <= stable[4:1];
            rep_cnt   <= '0;
            rep_on    <= 1'b0;
          end
        end
        ST_SWITCH: begin
          state     <= ST_HELD;
          held      <= 1'b1;
          held_code <= stable[4:1];
          rep_cnt   <= '0;
          rep_on    <= 1'b0;
        end
        ST_HELD: begin
          unique case (1'b1)
            key_up: begin
              state <= ST_IDLE;
              held  <= 1'b0;
            end
            key_new: state <= ST_SWITCH;
            rep_fire: begin
              rep_cnt <= '0;
              rep_on  <= 1'b1;
            end
            default: begin
              if (rep_cnt != REP_SAT) begin
                rep_cnt <= rep_cnt + 1'b1;
              end
            end
          endcase
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  event_fifo #(
    .WIDTH ($bits(key_event_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .wdata    (push_ev),
    .accepted (push_ok),
    .pop      (ev_ready),
    .rdata    (head),
    .empty    (fifo_empty)
  );

  assign ev_valid = !fifo_empty;
  assign ev_code  = head.code;
  assign ev_type  = head.ev_type;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push && !push_ok) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_event_rx.sv
// Scoreboard bench for keypad_event_rx against a behavioural key model.
// Directed test-plan scenarios followed by a randomized phase.
module tb_keypad_event_rx;
  import keypad_pkg::*;

  localparam int S     = 8;
  localparam int DLY   = 32;
  localparam int RATE  = 16;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic [4:0] keycode;
  logic       ev_valid;
  logic       ev_ready;
  logic [3:0] ev_code;
  logic [1:0] ev_type;
  logic       held;
  logic [3:0] held_code;
  logic       overflow;
  logic       clr_ovf;

  int checks = 0;
  int errors = 0;

  logic [5:0] sb_q[$];
  int         mcount;
  logic [4:0] m_stab, m_acc, m_prev;
  int         m_run;
  bit         m_held, m_sw, m_ovf;
  logic [3:0] m_code;
  int         m_t;
  bit         m_pop, m_have, m_drop;
  logic [5:0] m_ev;

  int         dur;
  logic [3:0] rc;

  keypad_event_rx #(
    .STABLE_CYCLES (S),
    .REPEAT_DELAY  (DLY),
    .REPEAT_RATE   (RATE),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .keycode   (keycode),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_code   (ev_code),
    .ev_type   (ev_type),
    .held      (held),
    .held_code (held_code),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t",
               name, act, expv, $time);
    end
  endtask

  task automatic drive(input logic [4:0] kc, input int n);
    keycode = kc;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: a key value is accepted once sampled on S+1
  // consecutive edges; the event handler sees it two edges later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stab = '0; m_acc = '0; m_prev = '0; m_run = 0;
      m_held = 0; m_sw = 0; m_ovf = 0; m_code = '0;
      m_t = 0; mcount = 0;
      sb_q.delete();
    end else begin
      m_pop  = (mcount > 0) && ev_ready;
      m_have = 0;
      m_ev   = '0;
      if (m_sw) begin
        m_have = 1; m_ev = {EV_PRESS, m_stab[4:1]};
        m_code = m_stab[4:1]; m_t = 0; m_sw = 0;
      end else if (!m_held) begin
        if (m_stab[0]) begin
          m_have = 1; m_ev = {EV_PRESS, m_stab[4:1]};
          m_code = m_stab[4:1]; m_t = 0; m_held = 1;
        end
      end else if (!m_stab[0]) begin
        m_have = 1; m_ev = {EV_RELEASE, m_code}; m_held = 0;
      end else if (m_stab[4:1] != m_code) begin
        m_have = 1; m_ev = {EV_RELEASE, m_code}; m_sw = 1;
      end else begin
        m_t++;
        if (DLY != 0 && m_t >= DLY && (m_t - DLY) % RATE == 0) begin
          m_have = 1; m_ev = {EV_REPEAT, m_code};
        end
      end
      m_drop = m_have && !(mcount < DEPTH || m_pop);
      if (m_have && !m_drop) begin
        sb_q.push_back(m_ev);
        mcount++;
      end
      if (m_drop) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      if (m_pop) mcount--;
      m_stab = m_acc;
      if (keycode == m_prev) m_run++;
      else begin
        m_prev = keycode;
        m_run  = 1;
      end
      if (m_run >= S + 1) m_acc = m_prev;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("ev_valid", ev_valid, mcount > 0);
      if (ev_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got %0h, expected none",
                   {ev_type, ev_code});
        end else begin
          check("event", {ev_type, ev_code}, sb_q[0]);
          if (ev_ready) void'(sb_q.pop_front());
        end
      end
      check("held", held, m_held);
      check("held_code", held_code, m_code);
      check("overflow", overflow, m_ovf);
    end
  end

  initial begin
    rst_n = 1'b0; keycode = 5'b0101_1;
    ev_ready = 1'b1; clr_ovf = 1'b0;
    #2;
    check("rst_ev_valid", ev_valid, 0);
    check("rst_ev_code", ev_code, 0);
    check("rst_ev_type", ev_type, 0);
    check("rst_held", held, 0);
    check("rst_held_code", held_code, 0);
    check("rst_overflow", overflow, 0);
    #10;
    @(posedge clk); #1;
    rst_n = 1'b1;

    repeat (10) @(posedge clk); #1;
    check("press_early", ev_valid, 0);
    @(posedge clk); #1;
    check("press_valid", ev_valid, 1);
    check("press_type", ev_type, EV_PRESS);
    check("press_code", ev_code, KEY_5);
    check("press_held", held, 1);
    check("press_hcode", held_code, KEY_5);

    drive(5'b0101_1, 40);
    drive(5'b0000_0, 20);
    drive(5'b0011_1, 5);
    drive(5'b0000_0, 20);
    check("glitch_held", held, 0);

    drive(5'b0101_1, 15);
    drive(5'b1100_1, 15);
    check("switch_hcode", held_code, KEY_C);

    drive(5'b0001_1, 110);
    drive(5'b0000_0, 20);
    check("release_held", held, 0);

    ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive((i % 2 == 0) ? 5'b0100_1 : 5'b0000_0, 12);
    end
    drive(5'b0100_1, 10);
    check("bp_overflow", overflow, 1);
    check("bp_valid", ev_valid, 1);
    check("bp_head", {ev_type, ev_code}, {EV_PRESS, KEY_4});
    ev_ready = 1'b1;
    drive(5'b0100_1, 10);
    check("bp_drained", ev_valid, 0);
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    check("ovf_cleared", overflow, 0);

    drive(5'b0000_0, 12);
    drive(5'b0010_1, 14);
    ev_ready = 1'b0;
    drive(5'b1101_1, 13);
    check("pre_rst_valid", ev_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", ev_valid, 0);
    check("arst_held", held, 0);
    check("arst_hcode", held_code, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ev_ready = 1'b1;
    repeat (10) @(posedge clk); #1;
    check("restart_early", ev_valid, 0);
    @(posedge clk); #1;
    check("restart_valid", ev_valid, 1);
    check("restart_head", {ev_type, ev_code}, {EV_PRESS, KEY_D});

    dur = 0;
    for (int n = 0; n < 3000; n++) begin
      if (dur == 0) begin
        rc = 4'($urandom_range(0, 15));
        keycode = {rc, 1'($urandom_range(0, 9) < 6)};
        dur = ($urandom_range(0, 5) == 0) ?
              $urandom_range(40, 90) : $urandom_range(1, 20);
      end
      dur--;
      ev_ready = ($urandom_range(0, 9) < 7);
      clr_ovf  = ($urandom_range(0, 49) == 0);
      @(posedge clk); #1;
    end

    clr_ovf = 1'b0;
    ev_ready = 1'b1;
    drive(5'b0000_0, 100);
    check("final_empty", ev_valid, 0);
    check("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
